// File: rtl/soc_gfx_pkg.sv
// Shared types for the graphics sequencing blocks.
// Holds the coordinate width, the coordinate and error-term types, the
// sequencer state encoding and the edge index type.
package soc_gfx_pkg;

    localparam int COORD_W = 9;
    localparam int ERR_W   = COORD_W + 2;

    typedef logic [COORD_W-1:0]      coord_t;
    typedef logic signed [ERR_W-1:0] err_t;
    typedef logic [1:0]              edge_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAW,
        NEXT,
        FINISH
    } seq_state_t;

    localparam coord_t    COORD_ONE = coord_t'(1);
    localparam err_t      ERR_ZERO  = err_t'(0);
    localparam edge_idx_t EDGE_ONE  = edge_idx_t'(1);
    localparam edge_idx_t LAST_EDGE = edge_idx_t'(2);

endpackage

// File: rtl/line_stepper.sv
// Bresenham line stepper.
// load     : latch start/end points and derive dx, dy, step directions, err.
// step     : advance one pixel along the line.
// xs..ye   : start and end point of the segment (used on load).
// x, y     : current pixel position.
// last     : the next step lands on the end point.
// zero_len : start equals end on the inputs (valid in the load cycle).
module line_stepper
    import soc_gfx_pkg::*;
(
    input  logic   HCLK,
    input  logic   HRESETn,
    input  logic   load,
    input  logic   step,
    input  coord_t xs,
    input  coord_t ys,
    input  coord_t xe,
    input  coord_t ye,
    output coord_t x,
    output coord_t y,
    output logic   last,
    output logic   zero_len
);

    coord_t x_q, y_q, xe_q, ye_q;
    err_t   dx_q, dy_q, err_q;
    logic   sx_neg_q, sy_neg_q;

    coord_t dx_abs, dy_abs, nx, ny;
    err_t   dx_ld, dy_ld, err_n;
    logic   step_x, step_y;

    // The doubled error can reach roughly three times the largest delta,
    // so the comparison is carried one bit wider than the error register.
    logic signed [ERR_W:0] e2, dx_w, dy_w;

    // Load-time deltas from the unregistered segment end points.
    always_comb begin
        dx_abs   = (xe >= xs) ? (xe - xs) : (xs - xe);
        dy_abs   = (ye >= ys) ? (ye - ys) : (ys - ye);
        dx_ld    = {2'b00, dx_abs};
        dy_ld    = {2'b00, dy_abs};
        zero_len = (xs == xe) && (ys == ye);
    end

    // One Bresenham step from the current position.
    always_comb begin
        e2     = {err_q, 1'b0};
        dx_w   = {dx_q[ERR_W-1], dx_q};
        dy_w   = {dy_q[ERR_W-1], dy_q};
        step_x = (e2 > -dy_w);
        step_y = (e2 < dx_w);
        err_n  = err_q - (step_x ? dy_q : ERR_ZERO) + (step_y ? dx_q : ERR_ZERO);
        nx     = x_q;
        ny     = y_q;
        if (step_x) nx = sx_neg_q ? (x_q - COORD_ONE) : (x_q + COORD_ONE);
        if (step_y) ny = sy_neg_q ? (y_q - COORD_ONE) : (y_q + COORD_ONE);
        last   = (nx == xe_q) && (ny == ye_q);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            x_q      <= '0;
            y_q      <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else if (load) begin
            x_q      <= xs;
            y_q      <= ys;
            xe_q     <= xe;
            ye_q     <= ye;
            dx_q     <= dx_ld;
            dy_q     <= dy_ld;
            err_q    <= dx_ld - dy_ld;
            sx_neg_q <= (xe < xs);
            sy_neg_q <= (ye < ys);
        end else if (step) begin
            x_q   <= nx;
            y_q   <= ny;
            err_q <= err_n;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: rtl/tri_edge_sequencer.sv
// Triangle outline sequencer.
// Snapshots three vertices on start and walks edges v1->v2, v2->v3, v3->v1
// through a Bresenham stepper, emitting one pixel per valid/ready beat.
// HCLK/HRESETn      : clock, asynchronous active-low reset.
// start/abort       : job request (IDLE only) and synchronous cancel.
// x1..y3            : vertex coordinates.
// pixel_x/y, pixel_valid, pixel_ready : pixel stream to the frame-buffer writer.
// edge_idx          : edge being drawn, 0 when idle.
// busy/done         : job in progress / one-cycle completion pulse.
module tri_edge_sequencer
    import soc_gfx_pkg::*;
(
    input  logic      HCLK,
    input  logic      HRESETn,
    input  logic      start,
    input  logic      abort,
    input  coord_t    x1,
    input  coord_t    y1,
    input  coord_t    x2,
    input  coord_t    y2,
    input  coord_t    x3,
    input  coord_t    y3,
    output coord_t    pixel_x,
    output coord_t    pixel_y,
    output logic      pixel_valid,
    input  logic      pixel_ready,
    output edge_idx_t edge_idx,
    output logic      busy,
    output logic      done
);

    seq_state_t state_q, state_d;
    edge_idx_t  edge_q;
    coord_t     vx1_q, vy1_q, vx2_q, vy2_q, vx3_q, vy3_q;
    coord_t     seg_xs, seg_ys, seg_xe, seg_ye;
    logic       capture, accept, degenerate, seg_last, seg_zero;

    assign capture    = (state_q == IDLE) && start && !abort;
    assign accept     = (state_q == DRAW) && pixel_ready;
    // All three vertices coincide: every edge is empty, so the final edge is
    // forced to draw its single start pixel.
    assign degenerate = (vx1_q == vx2_q) && (vx2_q == vx3_q) &&
                        (vy1_q == vy2_q) && (vy2_q == vy3_q);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            vx1_q <= '0; vy1_q <= '0;
            vx2_q <= '0; vy2_q <= '0;
            vx3_q <= '0; vy3_q <= '0;
        end else if (capture) begin
            vx1_q <= x1; vy1_q <= y1;
            vx2_q <= x2; vy2_q <= y2;
            vx3_q <= x3; vy3_q <= y3;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            edge_q <= '0;
        end else if (abort || capture || state_q == FINISH) begin
            edge_q <= '0;
        end else if (state_q == NEXT && edge_q != LAST_EDGE) begin
            edge_q <= edge_q + EDGE_ONE;
        end
    end

    always_comb begin
        seg_xs = vx3_q; seg_ys = vy3_q; seg_xe = vx1_q; seg_ye = vy1_q;
        case (edge_q)
            2'd0: begin seg_xs = vx1_q; seg_ys = vy1_q; seg_xe = vx2_q; seg_ye = vy2_q; end
            2'd1: begin seg_xs = vx2_q; seg_ys = vy2_q; seg_xe = vx3_q; seg_ye = vy3_q; end
            default: ;
        endcase
    end

    line_stepper u_stepper (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .load     (state_q == LOAD),
        .step     (accept),
        .xs       (seg_xs),
        .ys       (seg_ys),
        .xe       (seg_xe),
        .ye       (seg_ye),
        .x        (pixel_x),
        .y        (pixel_y),
        .last     (seg_last),
        .zero_len (seg_zero)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Abort overrides every transition.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   if (start) state_d = LOAD;
                LOAD:   state_d = (seg_zero && !(edge_q == LAST_EDGE && degenerate)) ? NEXT : DRAW;
                DRAW:   if (accept && seg_last) state_d = NEXT;
                NEXT:   state_d = (edge_q == LAST_EDGE) ? FINISH : LOAD;
                FINISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pixel_valid = (state_q == DRAW);
        busy        = (state_q == LOAD) || (state_q == DRAW) || (state_q == NEXT);
        done        = (state_q == FINISH);
        edge_idx    = busy ? edge_q : '0;
    end

endmodule

// File: tb/tb_tri_edge_sequencer.sv
module tb_tri_edge_sequencer;

    localparam int CW     = 9;
    localparam int BUDGET = 8000;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          pixel_ready = 1'b0;
    logic [CW-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, x3 = '0, y3 = '0;
    logic [CW-1:0] pixel_x, pixel_y;
    logic          pixel_valid, busy, done;
    logic [1:0]    edge_idx;

    always #5 HCLK = ~HCLK;

    tri_edge_sequencer dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .start       (start),
        .abort       (abort),
        .x1          (x1),
        .y1          (y1),
        .x2          (x2),
        .y2          (y2),
        .x3          (x3),
        .y3          (y3),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .edge_idx    (edge_idx),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        int x;
        int y;
        int e;
    } pix_t;

    typedef struct {
        int vx1, vy1, vx2, vy2, vx3, vy3;
        int stall;
        int abort_at;
        int disturb;
        int chk_lat;
        int exp_pixels;
    } vec_t;

    int   n_checks = 0;
    int   n_fail = 0;
    pix_t exp_q[$];
    pix_t got_q[$];
    int   done_count;
    vec_t tbl[8];
    int   t1x[12];
    int   t1y[12];

    // Every comparison funnels through here.
    task automatic checkOutput(input string what, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", what, actual, expected);
        end
    endtask

    // Reference pixel list: plain integer Bresenham per edge, end point excluded.
    task automatic build_model(input int ax1, input int ay1, input int ax2, input int ay2,
                               input int ax3, input int ay3);
        int vx[3];
        int vy[3];
        int xs, ys, xe, ye, dx, dy, sx, sy, err, e2, x, y;
        exp_q.delete();
        if (ax1 == ax2 && ax2 == ax3 && ay1 == ay2 && ay2 == ay3) begin
            exp_q.push_back('{ax1, ay1, -1});
            return;
        end
        vx[0] = ax1; vx[1] = ax2; vx[2] = ax3;
        vy[0] = ay1; vy[1] = ay2; vy[2] = ay3;
        for (int e = 0; e < 3; e++) begin
            xs = vx[e]; ys = vy[e];
            xe = vx[(e + 1) % 3]; ye = vy[(e + 1) % 3];
            dx = (xe > xs) ? xe - xs : xs - xe;
            dy = (ye > ys) ? ye - ys : ys - ye;
            sx = (xe >= xs) ? 1 : -1;
            sy = (ye >= ys) ? 1 : -1;
            err = dx - dy;
            x = xs; y = ys;
            while (!(x == xe && y == ye)) begin
                exp_q.push_back('{x, y, e});
                e2 = 2 * err;
                if (e2 > -dy) begin err -= dy; x += sx; end
                if (e2 < dx)  begin err += dx; y += sy; end
            end
        end
    endtask

    // Runs one job from start to done (or abort), collecting accepted pixels
    // and checking handshake behaviour cycle by cycle.
    task automatic applyStimulus(input vec_t v);
        int  cycles;
        bit  finished, prev_stall, abort_pending, r;
        int  px, py;
        build_model(v.vx1, v.vy1, v.vx2, v.vy2, v.vx3, v.vy3);
        got_q.delete();
        done_count = 0;
        x1 = CW'(v.vx1); y1 = CW'(v.vy1);
        x2 = CW'(v.vx2); y2 = CW'(v.vy2);
        x3 = CW'(v.vx3); y3 = CW'(v.vy3);
        @(negedge HCLK);
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        checkOutput("busy_after_start", int'(busy), 1);
        cycles = 0; finished = 0; prev_stall = 0; abort_pending = 0; px = 0; py = 0;
        while (!finished) begin
            if (cycles >= BUDGET) begin
                checkOutput("job_timeout", cycles, -1);
                break;
            end
            if (cycles == 1 && v.chk_lat != 0)
                checkOutput("first_valid_latency", int'(pixel_valid), 1);
            if (prev_stall) begin
                checkOutput("stall_valid_held", int'(pixel_valid), 1);
                checkOutput("stall_x_held", int'(pixel_x), px);
                checkOutput("stall_y_held", int'(pixel_y), py);
            end
            if (abort_pending) begin
                checkOutput("abort_valid", int'(pixel_valid), 0);
                checkOutput("abort_busy", int'(busy), 0);
                checkOutput("abort_done", int'(done), 0);
                finished = 1;
            end else if (done) begin
                done_count++;
                checkOutput("done_busy_low", int'(busy), 0);
                checkOutput("done_edge_zero", int'(edge_idx), 0);
                finished = 1;
            end
            if (!finished) begin
                case (v.stall)
                    0:       r = 1'b1;
                    1:       r = (cycles % 3 == 2);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                pixel_ready = r;
                abort = 1'b0;
                start = 1'b0;
                if (v.disturb != 0 && pixel_valid && (cycles % 5 == 0)) begin
                    start = 1'b1;
                    x1 = CW'($urandom_range(0, 511)); y1 = CW'($urandom_range(0, 511));
                    x2 = CW'($urandom_range(0, 511)); y2 = CW'($urandom_range(0, 511));
                    x3 = CW'($urandom_range(0, 511)); y3 = CW'($urandom_range(0, 511));
                end
                if (v.abort_at > 0 && got_q.size() >= v.abort_at) begin
                    abort = 1'b1;
                    abort_pending = 1;
                end
                if (pixel_valid && r)
                    got_q.push_back('{int'(pixel_x), int'(pixel_y), int'(edge_idx)});
                prev_stall = pixel_valid && !r;
                px = int'(pixel_x);
                py = int'(pixel_y);
                @(negedge HCLK);
                cycles++;
            end
        end
        pixel_ready = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        repeat (4) begin
            @(negedge HCLK);
            if (done) done_count++;
        end
        checkOutput("done_pulses", done_count, (v.abort_at > 0) ? 0 : 1);
        if (v.exp_pixels >= 0)
            checkOutput("pixel_count_table", got_q.size(), v.exp_pixels);
        if (v.abort_at == 0)
            checkOutput("pixel_count_model", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checkOutput($sformatf("pix%0d_x", i), got_q[i].x, exp_q[i].x);
            checkOutput($sformatf("pix%0d_y", i), got_q[i].y, exp_q[i].y);
            if (exp_q[i].e >= 0)
                checkOutput($sformatf("pix%0d_edge", i), got_q[i].e, exp_q[i].e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t rv;
        int   lim;
        t1x = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 0, 0, 0};
        t1y = '{0, 0, 0, 0, 0, 1, 2, 3, 4, 3, 2, 1};
        //         vertices                 stall abort dist lat pixels
        tbl[0] = '{0, 0, 4, 0, 0, 4,         0,    0,    0,   1,  12};
        tbl[1] = '{0, 0, 4, 0, 0, 4,         1,    0,    0,   1,  12};
        tbl[2] = '{7, 9, 7, 9, 7, 9,         0,    0,    0,   0,  1};
        tbl[3] = '{5, 5, 5, 5, 8, 5,         0,    0,    0,   0,  6};
        tbl[4] = '{0, 0, 4, 0, 0, 4,         2,    0,    1,   0,  12};
        tbl[5] = '{0, 0, 4, 0, 0, 4,         0,    3,    0,   1,  4};
        tbl[6] = '{0, 0, 4, 0, 0, 4,         0,    0,    0,   1,  12};
        tbl[7] = '{0, 0, 511, 511, 511, 0,   0,    0,    0,   1,  1533};

        @(negedge HCLK);
        checkOutput("reset_pixel_x", int'(pixel_x), 0);
        checkOutput("reset_pixel_y", int'(pixel_y), 0);
        checkOutput("reset_valid", int'(pixel_valid), 0);
        checkOutput("reset_edge", int'(edge_idx), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        for (int i = 0; i < 8; i++) begin
            $display("[TB] table vector %0d", i);
            applyStimulus(tbl[i]);
            if (i == 0 || i == 1) begin
                for (int k = 0; k < 12 && k < got_q.size(); k++) begin
                    checkOutput($sformatf("t1_lit%0d_x", k), got_q[k].x, t1x[k]);
                    checkOutput($sformatf("t1_lit%0d_y", k), got_q[k].y, t1y[k]);
                end
            end
        end

        for (int k = 0; k < 6; k++) begin
            lim = (k == 5) ? 511 : 40;
            rv = '{int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
                   int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
                   int'($urandom_range(0, lim)), int'($urandom_range(0, lim)),
                   (k == 5) ? 0 : 2, 0, 0, 0, -1};
            $display("[TB] random job %0d", k);
            applyStimulus(rv);
        end

        // Reset in the middle of the second edge of the extreme triangle.
        x1 = '0; y1 = '0; x2 = 9'd511; y2 = 9'd511; x3 = 9'd511; y3 = '0;
        pixel_ready = 1'b1;
        @(negedge HCLK);
        start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        repeat (700) @(negedge HCLK);
        checkOutput("pre_reset_edge", int'(edge_idx), 1);
        HRESETn = 1'b0;
        #1;
        checkOutput("midreset_pixel_x", int'(pixel_x), 0);
        checkOutput("midreset_pixel_y", int'(pixel_y), 0);
        checkOutput("midreset_valid", int'(pixel_valid), 0);
        checkOutput("midreset_edge", int'(edge_idx), 0);
        checkOutput("midreset_busy", int'(busy), 0);
        checkOutput("midreset_done", int'(done), 0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        done_count = 0;
        repeat (10) begin
            @(negedge HCLK);
            if (done || busy) done_count++;
        end
        checkOutput("post_reset_quiet", done_count, 0);
        pixel_ready = 1'b0;
        applyStimulus(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
